// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Reads command-sized bursts out of a show-ahead FIFO and presents the
//   words on a registered valid/ready stream with a last-beat marker.
//   The FIFO's empty flag is one cycle stale, so pops are spaced by at least
//   two cycles (a one-cycle gap follows every pop).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready burst command handshake, cmd_len = words to read (0 ok)
//   fifo_data       FIFO head word (show-ahead)
//   fifo_empty      FIFO empty flag (registered, one cycle stale)
//   fifo_next       pop strobe to FIFO
//   out_data/valid/ready/last  output stream
//   busy            burst in progress
//   done            one-cycle pulse after a burst completes
//   stall_cycles    saturating stall counter (FIFO_BURST_READER_STATS_EN),
//                   tied to zero otherwise
//
// Optional feature macro: FIFO_BURST_READER_STATS_EN
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_next,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 gap;
  logic                 pop;
  logic                 last_pop;

  assign last_pop = (remaining == LEN_WIDTH'(1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_len != '0))
          state_n = ACTIVE;
      end
      ACTIVE: begin
        pop = !fifo_empty && !gap && (!out_valid || out_ready);
        if (pop && last_pop)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign fifo_next = pop;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      gap       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      gap  <= 1'b0;
      if ((state == IDLE) && cmd_valid) begin
        if (cmd_len == '0)
          done <= 1'b1;
        else
          remaining <= cmd_len;
      end
      // A pop reloads the output register even when the current beat is
      // being accepted in the same cycle.
      if (pop) begin
        out_data  <= fifo_data;
        out_valid <= 1'b1;
        out_last  <= last_pop;
        remaining <= remaining - LEN_WIDTH'(1);
        gap       <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if ((state == DRAIN) && out_last)
          done <= 1'b1;
      end
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if ((state == ACTIVE) && !pop && !gap && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
